// File: rtl/icebreaker_pkg.sv
// Shared iCEBreaker board types: button vector, debounce default and per-button FSM states.
package icebreaker_pkg;

    typedef logic [3:0] BtnT;

    localparam int BTN_DEB_CYCLES_DEFAULT = 120_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PWAIT = 2'd1,
        HELD  = 2'd2,
        RWAIT = 2'd3
    } BtnState;

    // Bits needed to hold the values 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, debounce FSM with saturating hold counter.
// BTN_AUTOREPEAT_EN adds a repeat counter that re-pulses press_o while the button stays held.
module btn_debounce_ch
    import icebreaker_pkg::*;
#(
    parameter int DEB_CYCLES     = BTN_DEB_CYCLES_DEFAULT,
    parameter bit RAW_ACTIVE_LOW = 1'b0
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 6_000_000,
    parameter int REPEAT_PERIOD  = 1_200_000
`endif
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    raw_i,
    output logic    btn_o,
    output logic    press_o,
    output logic    release_o,
    output BtnState state_o
);

    localparam int              CNT_W    = cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    BtnState          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             btn_q;
    logic             press_q;
    logic             release_q;

    assign s     = sync_q[1] ^ RAW_ACTIVE_LOW;
    assign cnt_d = (cnt_q == CNT_TERM) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_q;
    logic             rep_phase_q;
    logic             rep_hit;

    // The first repeat waits REPEAT_DELAY; every later one waits REPEAT_PERIOD.
    assign rep_hit = (rep_q == (rep_phase_q ? REP_NEXT : REP_FIRST));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            btn_q       <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_phase_q <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], raw_i};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= PWAIT;
                        cnt_q   <= '0;
                    end
                end
                PWAIT: begin
                    if (!s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_TERM) begin
                        state_q     <= HELD;
                        cnt_q       <= '0;
                        btn_q       <= 1'b1;
                        press_q     <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rep_q       <= '0;
                        rep_phase_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_q <= RWAIT;
                        cnt_q   <= '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (rep_hit) begin
                        press_q     <= 1'b1;
                        rep_q       <= '0;
                        rep_phase_q <= 1'b1;
                    end else begin
                        rep_q <= rep_q + REP_W'(1);
                    end
`endif
                end
                RWAIT: begin
                    // The repeat counter is left untouched here so an aborted release resumes it.
                    if (s) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_TERM) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        btn_q       <= 1'b0;
                        release_q   <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rep_q       <= '0;
                        rep_phase_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_o     = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign state_o   = state_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces NUM_BTN asynchronous button pins into BtnT level and press/release pulse vectors.
// Define BTN_AUTOREPEAT_EN to make held buttons emit repeated press pulses.
module btn_debounce
    import icebreaker_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int DEB_CYCLES     = BTN_DEB_CYCLES_DEFAULT,
    parameter int RAW_ACTIVE_LOW = 0,
    parameter int REPEAT_DELAY   = 6_000_000,
    parameter int REPEAT_PERIOD  = 1_200_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_BTN-1:0]   btn_raw,
    output BtnT                  btn,
    output BtnT                  btn_press,
    output BtnT                  btn_release,
    output logic [2*NUM_BTN-1:0] dbg_state
);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $fatal(1, "btn_debounce: DEB_CYCLES must be >= 1");
    end
    if (NUM_BTN != $bits(BtnT)) begin : g_bad_num
        $fatal(1, "btn_debounce: NUM_BTN must match the width of BtnT");
    end
`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
        $fatal(1, "btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end
`else
    // Repeat timings have no effect in this build but must still be sane values.
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_bad_rep
        $fatal(1, "btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must not be negative");
    end
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .RAW_ACTIVE_LOW(RAW_ACTIVE_LOW != 0)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (btn_raw[i]),
            .btn_o    (btn[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .state_o  (dbg_state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed and random checks of btn_debounce against a sample-history reference model.
// Covers both builds; repeat expectations follow BTN_AUTOREPEAT_EN.
module tb_btn_debounce;
    import icebreaker_pkg::*;

    localparam int NB   = 4;
    localparam int DEB  = 8;
    localparam int RDLY = 40;
    localparam int RPER = 10;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    BtnT          btn;
    BtnT          btn_press;
    BtnT          btn_release;
    logic [7:0]   dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    btn_debounce #(
        .NUM_BTN       (NB),
        .DEB_CYCLES    (DEB),
        .RAW_ACTIVE_LOW(0),
        .REPEAT_DELAY  (RDLY),
        .REPEAT_PERIOD (RPER)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .btn        (btn),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .dbg_state  (dbg_state)
    );

    // Reference model: the pin value reaches the decision logic two edges late; the
    // debounced level flips once the last DEB+1 delayed samples all disagree with it.
    bit        m_d1      [NB];
    bit        m_d2      [NB];
    bit        m_last    [NB];
    bit        m_run_val [NB];
    int        m_run_len [NB];
    int        m_held    [NB];
    logic [NB-1:0] m_btn, m_press, m_rel;

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_d1[i]      = 1'b0;
            m_d2[i]      = 1'b0;
            m_last[i]    = 1'b0;
            m_run_val[i] = 1'b0;
            m_run_len[i] = DEB + 1;
            m_held[i]    = 0;
        end
        m_btn   = '0;
        m_press = '0;
        m_rel   = '0;
    endfunction

    function automatic void model_edge(input logic [NB-1:0] r);
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < NB; i++) begin
            bit s;
            s       = m_d2[i];
            m_d2[i] = m_d1[i];
            m_d1[i] = r[i];
            if (s == m_run_val[i]) begin
                if (m_run_len[i] < 100_000) m_run_len[i]++;
            end else begin
                m_run_val[i] = s;
                m_run_len[i] = 1;
            end
            if (m_run_len[i] >= DEB + 1 && m_run_val[i] != m_btn[i]) begin
                m_btn[i] = s;
                if (s) m_press[i] = 1'b1;
                else   m_rel[i]   = 1'b1;
                m_held[i] = 0;
            end else if (AR && m_btn[i] && m_last[i] && s) begin
                // Held time only accrues across consecutive pressed samples.
                m_held[i]++;
                if (m_held[i] == RDLY || (m_held[i] > RDLY && (m_held[i] - RDLY) % RPER == 0))
                    m_press[i] = 1'b1;
            end
            m_last[i] = s;
        end
    endfunction

    // checkers
    task automatic check4(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver: one clock edge, model update, then compare 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge(btn_raw);
        #1;
        check4("btn", btn, m_btn);
        check4("press", btn_press, m_press);
        check4("release", btn_release, m_rel);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        model_reset();
        repeat (n) tick();
    endtask

    task automatic settle();
        btn_raw = '0;
        repeat (DEB + 6) tick();
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    initial begin
        int lat;
        int cnt;
        int cnt2;
        int hold [NB];
        logic [NB-1:0] pv;

        // 1: pins held through reset
        btn_raw = 4'b1111;
        do_reset(3);
        check4("t1_reset_btn", btn, 4'b0000);
        check8("t1_reset_state", dbg_state, 8'h00);
        reset_n = 1'b1;
        lat = -1; pv = '0; cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (btn_release != '0) cnt++;
            if (lat < 0 && btn_press != '0) begin
                lat = k;
                pv  = btn_press;
            end
        end
        check_int("t1_latency", lat, DEB + 2);
        check4("t1_press_vec", pv, 4'b1111);
        check_int("t1_release_cnt", cnt, 0);
        check8("t1_state_held", dbg_state, {HELD, HELD, HELD, HELD});

        // 2: short pulse rejected, then a real press
        settle();
        btn_raw = 4'b0001;
        cnt = 0;
        repeat (5) begin tick(); if (btn_press[0] || btn[0]) cnt++; end
        btn_raw = 4'b0000;
        repeat (15) begin tick(); if (btn_press[0] || btn[0]) cnt++; end
        check_int("t2_short_rejected", cnt, 0);
        btn_raw = 4'b0001;
        lat = -1; cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (btn_press[0]) cnt++;
            if (lat < 0 && btn[0]) lat = k;
        end
        check_int("t2_latency", lat, DEB + 2);
        check_int("t2_press_cnt", cnt, 1);

        // 3: bouncing while held, then a clean release
        cnt = 0; cnt2 = 0;
        for (int k = 0; k <= 20; k++) begin
            btn_raw[0] = (k % 2 == 0);
            tick();
            if (!btn[0]) cnt++;
            if (btn_release[0]) cnt2++;
        end
        btn_raw[0] = 1'b0;
        lat = -1;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (btn_release[0]) begin
                cnt2++;
                if (lat < 0) lat = k;
            end
        end
        check_int("t3_no_glitch", cnt, 0);
        check_int("t3_release_lat", lat, DEB + 2);
        check_int("t3_release_cnt", cnt2, 1);

        // 4: simultaneous press on two channels, release one
        btn_raw = 4'b1010;
        cnt = 0; pv = '0;
        repeat (15) begin tick(); if (btn_press != '0) begin cnt++; pv = btn_press; end end
        check_int("t4_press_cycles", cnt, 1);
        check4("t4_press_vec", pv, 4'b1010);
        btn_raw = 4'b0010;
        cnt = 0; pv = '0;
        repeat (15) begin tick(); if (btn_release != '0) begin cnt++; pv = btn_release; end end
        check_int("t4_release_cycles", cnt, 1);
        check4("t4_release_vec", pv, 4'b1000);

        // 5: reset in the middle of a press count
        settle();
        btn_raw = 4'b0001;
        cnt = 0;
        repeat (7) begin tick(); if (btn_press[0]) cnt++; end
        do_reset(3);
        check4("t5_reset_btn", btn, 4'b0000);
        reset_n = 1'b1;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (lat < 0 && btn_press[0]) lat = k;
        end
        check_int("t5_no_pulse_before", cnt, 0);
        check_int("t5_latency", lat, DEB + 2);

        // 6: long hold on channel 2
        settle();
        btn_raw = 4'b0100;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (btn_press[2]) begin cnt = 1; break; end
        end
        check_int("t6_accepted", cnt, 1);
        exp_q.delete();
        got_q.delete();
        exp_q.push_back(8'd0);
        if (AR) for (int o = RDLY; o < 100; o += RPER) exp_q.push_back(8'(o));
        if (cnt == 1) got_q.push_back(8'd0);
        for (int o = 1; o < 100; o++) begin
            tick();
            if (btn_press[2]) got_q.push_back(8'(o));
        end
        check_int("t6_pulse_cnt", got_q.size(), AR ? 7 : 1);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hff;
            check8("t6_pulse_offset", g, e);
        end

        // 7: random bouncing on all channels
        settle();
        for (int i = 0; i < NB; i++) hold[i] = 1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NB; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    hold[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 70))
                                                          : int'($urandom_range(1, 12));
                end
            end
            tick();
        end
        settle();
        check4("final_btn_idle", btn, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
